// File: rtl/cmd_scheduler.sv
// Command scheduler: pops timed commands from the command FIFO, waits for the
// global time base to reach each command's start time, then dispatches it to
// the addressed controller over a single req/ack bus. One command in flight.
module cmd_scheduler #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] global_clock,
  input  logic [79:0] cmd_fifo_data_out,
  input  logic        cmd_fifo_empty,
  output logic        cmd_fifo_rd_en,
  input  logic        flush,
  output logic [7:0]  ctrl_addr,
  output logic [7:0]  ctrl_opcode,
  output logic [31:0] ctrl_data,
  output logic        ctrl_req,
  input  logic        ctrl_ack,
  output logic        busy,
  output logic [15:0] late_count,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_TIME = 2'd2,
    REQ       = 2'd3
  } state_t;

  // Last ack-counter value before the command is abandoned.
  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      state_n;
  logic [79:0] hold;
  logic [15:0] ack_cnt;
  logic        first_wait;
  logic [31:0] start_time;
  logic        time_reached;
  logic        is_late;
  logic        ack_expired;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign start_time   = hold[63:32];
  assign time_reached = (global_clock >= start_time);
  // start_time of zero means "now" and is never late.
  assign is_late      = first_wait && (start_time != 32'd0) && (global_clock > start_time);
  assign ack_expired  = (ack_cnt == ACK_LAST);
  assign busy         = (state != IDLE);

  // Next-state and FIFO pop strobe; flush/rst override everything.
  always_comb begin
    state_n        = state;
    cmd_fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (!cmd_fifo_empty) begin
          cmd_fifo_rd_en = 1'b1;
          state_n        = FETCH;
        end
      end
      FETCH:     state_n = WAIT_TIME;
      WAIT_TIME: if (time_reached) state_n = REQ;
      REQ:       if (ctrl_ack || ack_expired) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    if (flush || rst) begin
      state_n        = IDLE;
      cmd_fifo_rd_en = 1'b0;
    end
  end

  // State, hold register, registered bus outputs and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold        <= '0;
      ack_cnt     <= '0;
      first_wait  <= 1'b0;
      ctrl_req    <= 1'b0;
      ctrl_addr   <= '0;
      ctrl_opcode <= '0;
      ctrl_data   <= '0;
      late_count  <= '0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_n;
      ctrl_req   <= (state_n == REQ);
      first_wait <= (state == FETCH) && !flush;
      ack_cnt    <= (state == REQ) ? ack_cnt + 16'd1 : 16'd0;
      // A word arriving during a flush is dropped, not captured.
      if (state == FETCH && !flush) hold <= cmd_fifo_data_out;
      // Bus fields are loaded once on entry to REQ and held stable afterwards.
      if (state == WAIT_TIME && state_n == REQ) begin
        ctrl_addr   <= hold[79:72];
        ctrl_opcode <= hold[71:64];
        ctrl_data   <= hold[31:0];
      end
      if (flush) begin
        late_count  <= '0;
        err_timeout <= 1'b0;
      end else begin
        if (state == WAIT_TIME && is_late) late_count <= sat_inc16(late_count);
        // An ack in the expiry cycle still counts as accepted.
        if (state == REQ && !ctrl_ack && ack_expired) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Bench for cmd_scheduler: directed scenarios plus randomized command batches,
// checked against a transaction-level timing model of the scheduler.
module tb_cmd_scheduler;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] global_clock;
  logic [79:0] fifo_dout = '0;
  logic        cmd_fifo_empty;
  logic        cmd_fifo_rd_en;
  logic        flush;
  logic [7:0]  ctrl_addr;
  logic [7:0]  ctrl_opcode;
  logic [31:0] ctrl_data;
  logic        ctrl_req;
  logic        ctrl_ack;
  logic        busy;
  logic [15:0] late_count;
  logic        err_timeout;

  logic        gc_run;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_late;
  logic        exp_err;

  // FIFO model: written by the stimulus, popped one cycle after rd_en.
  logic [79:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        rd_seen = 1'b0;

  assign cmd_fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  always @(negedge clk) rd_seen <= cmd_fifo_rd_en;

  always @(posedge clk) begin
    if (rd_seen) begin
      fifo_dout <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  cmd_scheduler #(.ACK_TIMEOUT(T)) dut (
    .clk               (clk),
    .rst               (rst),
    .global_clock      (global_clock),
    .cmd_fifo_data_out (fifo_dout),
    .cmd_fifo_empty    (cmd_fifo_empty),
    .cmd_fifo_rd_en    (cmd_fifo_rd_en),
    .flush             (flush),
    .ctrl_addr         (ctrl_addr),
    .ctrl_opcode       (ctrl_opcode),
    .ctrl_data         (ctrl_data),
    .ctrl_req          (ctrl_req),
    .ctrl_ack          (ctrl_ack),
    .busy              (busy),
    .late_count        (late_count),
    .err_timeout       (err_timeout)
  );

  task automatic ckw(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ck1(input string tag, input logic obs, input logic exp);
    ckw(tag, {79'd0, obs}, {79'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (gc_run) global_clock = global_clock + 32'd1;
  endtask

  task automatic push(input logic [79:0] c);
    mem[wr_ptr[7:0]] = c;
    wr_ptr++;
  endtask

  function automatic logic [79:0] mk(input logic [7:0] a, input logic [7:0] op,
                                     input logic [31:0] st, input logic [31:0] d);
    return {a, op, st, d};
  endfunction

  // Runs one command from its pop cycle to the first idle cycle afterwards.
  // Model: WAIT_TIME begins 2 cycles after the pop; the request rises the
  // cycle after the first WAIT_TIME cycle whose time is >= start; an ack
  // ack_dly cycles into REQ ends it, otherwise it lasts exactly T cycles.
  task automatic dispatch(input logic [79:0] c, input int ack_dly, input bit noise,
                          input string tag);
    int          rd_c;
    int          w;
    int          r_exp;
    int          r_end;
    logic [31:0] st;
    logic [31:0] gw;
    bit          to;
    #1;
    ck1({tag, "_rd_en"}, cmd_fifo_rd_en, 1'b1);
    ck1({tag, "_idle"}, busy, 1'b0);
    st   = c[63:32];
    rd_c = cyc;
    w    = rd_c + 2;
    gw   = gc_run ? global_clock + 32'd2 : global_clock;
    if (gw >= st) r_exp = w + 1;
    else          r_exp = w + 1 + int'(st - gw);
    if (st != 32'd0 && gw > st && exp_late != 16'hFFFF) exp_late = exp_late + 16'd1;
    to    = (ack_dly >= T);
    r_end = to ? r_exp + T : r_exp + ack_dly + 1;
    if (to) exp_err = 1'b1;
    while (cyc < r_end) begin
      tick();
      if (cyc < r_exp) ctrl_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      else             ctrl_ack = (!to && cyc == r_exp + ack_dly);
      ck1({tag, "_req"}, ctrl_req, (cyc >= r_exp && cyc < r_end));
      ck1({tag, "_busy"}, busy, (cyc < r_end));
      if (cyc < r_end) ck1({tag, "_rd_quiet"}, cmd_fifo_rd_en, 1'b0);
      if (cyc >= r_exp && cyc < r_end) begin
        ckw({tag, "_addr"}, 80'(ctrl_addr), 80'(c[79:72]));
        ckw({tag, "_opcode"}, 80'(ctrl_opcode), 80'(c[71:64]));
        ckw({tag, "_data"}, 80'(ctrl_data), 80'(c[31:0]));
      end
      if (cyc == w + 1) ckw({tag, "_late"}, 80'(late_count), 80'(exp_late));
    end
    ctrl_ack = 1'b0;
    ck1({tag, "_err_end"}, err_timeout, exp_err);
    ckw({tag, "_late_end"}, 80'(late_count), 80'(exp_late));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] c1;
    logic [79:0] c2;
    logic [79:0] c3;
    logic [79:0] batch [$];
    logic [31:0] st;
    int          base;
    int          n;

    rst          = 1'b1;
    flush        = 1'b0;
    ctrl_ack     = 1'b0;
    global_clock = 32'd0;
    gc_run       = 1'b0;
    exp_late     = 16'd0;
    exp_err      = 1'b0;
    tick();
    tick();

    // Reset state.
    ck1("rst_req", ctrl_req, 1'b0);
    ckw("rst_addr", 80'(ctrl_addr), 80'(0));
    ckw("rst_opcode", 80'(ctrl_opcode), 80'(0));
    ckw("rst_data", 80'(ctrl_data), 80'(0));
    ck1("rst_busy", busy, 1'b0);
    ckw("rst_late", 80'(late_count), 80'(0));
    ck1("rst_err", err_timeout, 1'b0);

    // Immediate dispatch; command queued while still in reset must not pop.
    c1 = mk(8'h03, 8'h01, 32'd0, 32'h0000_00AA);
    push(c1);
    #1;
    ck1("rst_rd_blocked", cmd_fifo_rd_en, 1'b0);
    tick();
    rst = 1'b0;
    dispatch(c1, 2, 1'b0, "imm");

    // Timed dispatch: start 100, time base at 40 and running.
    global_clock = 32'd40;
    gc_run       = 1'b1;
    push(mk(8'h11, 8'h22, 32'd100, 32'hCAFE_0100));
    dispatch(mk(8'h11, 8'h22, 32'd100, 32'hCAFE_0100), 0, 1'b1, "timed");

    // Late command: time 500, start 200.
    gc_run       = 1'b0;
    global_clock = 32'd500;
    c1 = mk(8'h40, 8'h02, 32'd200, 32'h0000_0200);
    push(c1);
    dispatch(c1, 1, 1'b0, "late");

    // Start exactly equal to the time base: on time, not late.
    c1 = mk(8'h41, 8'h03, 32'd500, 32'h0000_0500);
    push(c1);
    dispatch(c1, 0, 1'b0, "ontime");

    // Ack in the last allowed REQ cycle wins over the timeout.
    c1 = mk(8'h50, 8'h07, 32'd0, 32'h7777_0007);
    push(c1);
    dispatch(c1, T - 1, 1'b0, "ack_last");

    // Timeout, then the next queued command is popped.
    c1 = mk(8'h51, 8'h08, 32'd0, 32'h8888_0008);
    c2 = mk(8'h52, 8'h09, 32'd0, 32'h9999_0009);
    push(c1);
    push(c2);
    dispatch(c1, T, 1'b0, "timeout");
    dispatch(c2, 0, 1'b0, "after_to");

    // Back-to-back: three queued commands, each acked the cycle after req.
    base = rd_ptr;
    c1 = mk(8'h61, 8'hA1, 32'd0, 32'h0000_0001);
    c2 = mk(8'h62, 8'hA2, 32'd0, 32'h0000_0002);
    c3 = mk(8'h63, 8'hA3, 32'd0, 32'h0000_0003);
    push(c1);
    push(c2);
    push(c3);
    dispatch(c1, 1, 1'b0, "b2b1");
    dispatch(c2, 1, 1'b0, "b2b2");
    dispatch(c3, 1, 1'b0, "b2b3");
    repeat (3) begin
      tick();
      ck1("b2b_idle_busy", busy, 1'b0);
      ck1("b2b_idle_rd", cmd_fifo_rd_en, 1'b0);
      ck1("b2b_idle_req", ctrl_req, 1'b0);
    end
    ckw("b2b_pops", 80'(rd_ptr - base), 80'(3));

    // Flush while waiting on a stalled time base; flush also blocks the pop
    // of the next queued word, which remains in the FIFO.
    gc_run       = 1'b0;
    global_clock = 32'd10;
    c1 = mk(8'h21, 8'h05, 32'd1000, 32'hDEAD_0001);
    c2 = mk(8'h22, 8'h06, 32'd0, 32'hBEEF_0002);
    push(c1);
    push(c2);
    #1;
    ck1("fl_rd", cmd_fifo_rd_en, 1'b1);
    repeat (8) begin
      tick();
      ck1("fl_wait_busy", busy, 1'b1);
      ck1("fl_wait_req", ctrl_req, 1'b0);
    end
    flush = 1'b1;
    tick();
    ck1("fl_busy", busy, 1'b0);
    ck1("fl_req", ctrl_req, 1'b0);
    ckw("fl_late", 80'(late_count), 80'(0));
    ck1("fl_err", err_timeout, 1'b0);
    ck1("fl_rd_forced", cmd_fifo_rd_en, 1'b0);
    exp_late = 16'd0;
    exp_err  = 1'b0;
    flush    = 1'b0;
    dispatch(c2, 0, 1'b0, "fl_next");

    // Randomized batches against the timing model.
    global_clock = 32'd5000;
    gc_run       = 1'b1;
    for (int b = 0; b < 10; b++) begin
      n = $urandom_range(1, 3);
      batch.delete();
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 3))
          0:       st = 32'd0;
          1:       st = global_clock - 32'($urandom_range(1, 30));
          default: st = global_clock + 32'($urandom_range(0, 60));
        endcase
        c1 = mk(8'($urandom), 8'($urandom), st, $urandom);
        push(c1);
        batch.push_back(c1);
      end
      for (int j = 0; j < n; j++) dispatch(batch[j], $urandom_range(0, 9), 1'b1, "rnd");
    end

    // Reset while a request is outstanding.
    gc_run = 1'b0;
    c1 = mk(8'h5A, 8'hC3, 32'd0, 32'h1234_5678);
    push(c1);
    #1;
    ck1("rr_rd", cmd_fifo_rd_en, 1'b1);
    tick();
    tick();
    tick();
    ck1("rr_req_up", ctrl_req, 1'b1);
    ckw("rr_addr_up", 80'(ctrl_addr), 80'(8'h5A));
    rst = 1'b1;
    tick();
    ck1("rr_req", ctrl_req, 1'b0);
    ckw("rr_addr", 80'(ctrl_addr), 80'(0));
    ckw("rr_opcode", 80'(ctrl_opcode), 80'(0));
    ckw("rr_data", 80'(ctrl_data), 80'(0));
    ck1("rr_busy", busy, 1'b0);
    ckw("rr_late", 80'(late_count), 80'(0));
    ck1("rr_err", err_timeout, 1'b0);
    ck1("rr_rd", cmd_fifo_rd_en, 1'b0);
    rst = 1'b0;
    tick();
    ck1("rr_idle_busy", busy, 1'b0);
    ck1("rr_idle_req", ctrl_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
